jk_excitation_sequencer: RTL and testbench

Drives a bank of WIDTH JK flip-flops toward a requested target value by generating per-bit J/K excitation codes, the inverse of the JK cell's characteristic function. It accepts a target through a valid/ready handshake. It then reaches the target either in one jump or by stepping ±1 per cycle. It keeps an internal model q of the driven bank, which an external bank of JK cells on the same clock must track exactly.

---
 rtl/jk_excitation_sequencer.sv | 105 ++++++++++
 tb/tb_jk_excitation_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_sequencer.sv
// Drives a bank of JK cells toward a requested target, either in one jump or by
// +/-1 steps, while keeping an exact model q of the driven bank.
module jk_excitation_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] target,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, APPLY, STEP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic             md;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] q_jk;

  // Inverse JK characteristic with don't-cares forced to 0: returns {j, k}.
  function automatic logic [2*WIDTH-1:0] ex(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] nx);
    return {nx & ~cur, cur & ~nx};
  endfunction

  always_comb begin
    nxt = (tgt > q) ? q + 1'b1 : q - 1'b1;
  end

  always_comb begin
    j = '0;
    k = '0;
    case (state)
      APPLY:   {j, k} = ex(q, tgt);
      STEP:    {j, k} = ex(q, nxt);
      default: {j, k} = '0;
    endcase
  end

  // JK rule for the modelled bank; toggle (11) is never driven.
  always_comb begin
    q_jk = (q & ~k) | j;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      tgt        <= '0;
      md         <= 1'b0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      q <= q_jk;
      case (state)
        IDLE: begin
          if (load_valid) begin
            tgt        <= target;
            md         <= mode;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            if (target == q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= mode ? STEP : APPLY;
              done  <= 1'b0;
            end
          end
        end
        APPLY: begin
          state <= DONE;
          done  <= 1'b1;
        end
        STEP: begin
          if (nxt == tgt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Directed bench for jk_excitation_sequencer with a shadow JK bank tracking q.
module tb_jk_excitation_sequencer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] target;
  logic             mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow;

  int n_cmp = 0;
  int n_err = 0;

  jk_excitation_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .target(target), .mode(mode), .j(j), .k(k), .q(q), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK bank with full JK semantics, including toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= '0;
    else begin
      for (int b = 0; b < WIDTH; b++) begin
        case ({j[b], k[b]})
          2'b01:   shadow[b] <= 1'b0;
          2'b10:   shadow[b] <= 1'b1;
          2'b11:   shadow[b] <= ~shadow[b];
          default: shadow[b] <= shadow[b];
        endcase
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    assert (shadow === q) else begin
      n_err++;
      $error("FAIL shadow_bank observed=%h expected=%h", q, shadow);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ej, input logic [3:0] ek,
                         input logic [3:0] eq, input logic er, input logic eb,
                         input logic ed);
    check({tag, "_j"}, 32'(j), 32'(ej));
    check({tag, "_k"}, 32'(k), 32'(ek));
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_ready"}, 32'(load_ready), 32'(er));
    check({tag, "_busy"}, 32'(busy), 32'(eb));
    check({tag, "_done"}, 32'(done), 32'(ed));
  endtask

  // Issue a request in the current IDLE cycle; the next edge accepts it.
  task automatic request(input logic [3:0] t, input logic m);
    load_valid = 1'b1;
    target     = t;
    mode       = m;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    target     = '0;
    mode       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("idle0", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Jump 0 -> A; target changes after acceptance must be ignored.
    request(4'hA, 1'b0);
    target = 4'h0;
    mode   = 1'b1;
    chk_out("jmpA_apply", 4'hA, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("jmpA_done", 4'h0, 4'h0, 4'hA, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("jmpA_idle", 4'h0, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0);

    // Jump A -> 5.
    request(4'h5, 1'b0);
    chk_out("jmp5_apply", 4'h5, 4'hA, 4'hA, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("jmp5_done", 4'h0, 4'h0, 4'h5, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("jmp5_idle", 4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0);

    // Equal target: DONE directly, no j/k activity.
    request(4'h5, 1'b1);
    chk_out("eq_done", 4'h0, 4'h0, 4'h5, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("eq_idle", 4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0);

    // Jump 5 -> 3 to set up the step-up case.
    request(4'h3, 1'b0);
    chk_out("jmp3_apply", 4'h2, 4'h4, 4'h5, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("jmp3_idle", 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0);

    // Step 3 -> 6 while load_valid/target toggle (must be ignored).
    request(4'h6, 1'b1);
    load_valid = 1'b1;
    target     = 4'h0;
    chk_out("up_s1", 4'h4, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    target     = 4'hF;
    chk_out("up_s2", 4'h1, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0);
    tick();
    load_valid = 1'b1;
    chk_out("up_s3", 4'h2, 4'h1, 4'h5, 1'b0, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    chk_out("up_done", 4'h0, 4'h0, 4'h6, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("up_idle", 4'h0, 4'h0, 4'h6, 1'b1, 1'b0, 1'b0);

    // Jump 6 -> 2, then step down 2 -> 0.
    request(4'h2, 1'b0);
    tick();
    tick();
    check("dn_setup_q", 32'(q), 32'h2);
    request(4'h0, 1'b1);
    chk_out("dn_s1", 4'h1, 4'h2, 4'h2, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("dn_s2", 4'h0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("dn_done", 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("dn_idle", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Step 0 -> F, reset asynchronously once q reaches 7.
    request(4'hF, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk_out("long_q7", 4'h8, 4'h7, 4'h7, 1'b0, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rst_hold", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("post_rst", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Short jump after reset to confirm the block is usable again.
    request(4'h9, 1'b0);
    chk_out("rec_apply", 4'h9, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("rec_done", 4'h0, 4'h0, 4'h9, 1'b0, 1'b1, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
